serial_operand_shifter: RTL and testbench

Upstream feeder for the bit-serial adder. Accepts one parallel operand pair (A, B) per transaction over a valid/ready handshake. Emits the pair LSB-first, one bit of each per accepted beat, with first/last framing so the adder can clear its carry on `bit_first` and latch its result after `bit_last`. Supports back-to-back words and downstream backpressure.

---
 rtl/serial_pkg.sv | 13 +
 rtl/piso_shreg.sv | 40 ++++
 rtl/serial_operand_shifter.sv | 119 +++++++++++
 tb/tb_serial_operand_shifter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial datapath (operand shifter, serial adder, collector).
//   OperandWidth   : default operand width in bits
//   serial_state_e : operand shifter FSM encoding (StIdle=0, StShift=1)
package serial_pkg;

    localparam int unsigned OperandWidth = 4;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StShift = 1'b1
    } serial_state_e;

endpackage

// File: rtl/piso_shreg.sv
// Parallel-in / serial-out shift register, LSB out first.
//   clk       : rising-edge clock
//   reset     : asynchronous active-low reset, clears the register
//   load      : capture load_data (has priority over shift)
//   shift     : shift right by one, zero fill
//   load_data : parallel word to capture
//   ser_out   : current LSB of the register
module piso_shreg #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_out
);

    logic [WIDTH-1:0] sh_q, sh_d;

    always_comb begin
        sh_d = sh_q;
        if (load) begin
            sh_d = load_data;
        end else if (shift) begin
            sh_d = sh_q >> 1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign ser_out = sh_q[0];

endmodule

// File: rtl/serial_operand_shifter.sv
// Serialises one parallel operand pair (A, B) per handshake into LSB-first beats with
// first/last framing for the bit-serial adder.
//   clk, reset           : clock, asynchronous active-low reset
//   in_valid/in_ready    : parallel operand handshake, in_a/in_b sampled on accept
//   bit_valid/bit_ready  : serial beat handshake
//   bit_a, bit_b         : current bits of A and B
//   bit_first, bit_last  : beat is bit 0 / bit WIDTH-1 of the word
//   busy                 : a word is in flight
module serial_operand_shifter
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = OperandWidth
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             bit_a,
    output logic             bit_b,
    output logic             bit_first,
    output logic             bit_last,
    output logic             busy
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    serial_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load, shift;
    logic             sh_a_lsb, sh_b_lsb;
    logic             shifting;
    logic             at_last;

    assign shifting = (state_q == StShift);
    assign at_last  = (cnt_q == LastCnt);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        bit_valid = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                bit_valid = 1'b1;
                if (bit_ready) begin
                    if (at_last) begin
                        // Last transfer frees the slot: take the next pair with no bubble.
                        in_ready = 1'b1;
                        if (in_valid) begin
                            load  = 1'b1;
                            cnt_d = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        shift = 1'b1;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    piso_shreg #(
        .WIDTH(WIDTH)
    ) u_sh_a (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .shift    (shift),
        .load_data(in_a),
        .ser_out  (sh_a_lsb)
    );

    piso_shreg #(
        .WIDTH(WIDTH)
    ) u_sh_b (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .shift    (shift),
        .load_data(in_b),
        .ser_out  (sh_b_lsb)
    );

    // Beat outputs are forced low outside SHIFT so idle leftovers never show.
    assign bit_a     = shifting & sh_a_lsb;
    assign bit_b     = shifting & sh_b_lsb;
    assign bit_first = shifting & (cnt_q == '0);
    assign bit_last  = shifting & at_last;
    assign busy      = shifting;

endmodule

// File: tb/tb_serial_operand_shifter.sv
module tb_serial_operand_shifter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, bit_valid, bit_ready;
    logic [W-1:0] in_a, in_b;
    logic         bit_a, bit_b, bit_first, bit_last, busy;

    logic         v1, r1, br1, bv1, ba1, bb1, bf1, bl1, busy1;
    logic [0:0]   a1, b1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Behavioural model: current word, bit index, and queue of accepted words.
    bit           m_busy = 1'b0;
    logic [W-1:0] m_a, m_b;
    int           m_idx = 0;
    logic [W-1:0] acc_a[$], acc_b[$];
    logic [W-1:0] col_a, col_b;
    int           col_n = 0;

    // Log of DUT transfers, for literal pins.
    logic la[$], lb[$], lf[$], ll[$];
    int   lcyc[$];

    serial_operand_shifter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .bit_valid(bit_valid), .bit_ready(bit_ready),
        .bit_a(bit_a), .bit_b(bit_b), .bit_first(bit_first), .bit_last(bit_last),
        .busy(busy)
    );

    serial_operand_shifter #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(v1), .in_ready(r1),
        .in_a(a1), .in_b(b1), .bit_valid(bv1), .bit_ready(br1),
        .bit_a(ba1), .bit_b(bb1), .bit_first(bf1), .bit_last(bl1),
        .busy(busy1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_ready();
        return !m_busy || (m_idx == W - 1 && bit_ready);
    endfunction

    // Model update and transfer collector, on the active edge.
    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_busy = 1'b0;
                m_idx  = 0;
                col_n  = 0;
                acc_a.delete();
                acc_b.delete();
            end else begin
                bit acc;
                cyc++;
                acc = in_valid && exp_ready();
                if (bit_valid && bit_ready) begin
                    la.push_back(bit_a);
                    lb.push_back(bit_b);
                    lf.push_back(bit_first);
                    ll.push_back(bit_last);
                    lcyc.push_back(cyc);
                    if (col_n < W) begin
                        col_a[col_n] = bit_a;
                        col_b[col_n] = bit_b;
                    end
                    col_n++;
                    if (bit_last) begin
                        check("word_len", col_n, W);
                        if (acc_a.size() == 0) begin
                            check("word_extra", 1, 0);
                        end else begin
                            check("word_a", col_a, acc_a.pop_front());
                            check("word_b", col_b, acc_b.pop_front());
                        end
                        col_n = 0;
                    end
                end
                if (m_busy && bit_ready) begin
                    if (m_idx == W - 1) begin
                        if (acc) begin
                            m_a = in_a; m_b = in_b; m_idx = 0;
                        end else begin
                            m_busy = 1'b0;
                        end
                    end else begin
                        m_idx++;
                    end
                end else if (!m_busy && acc) begin
                    m_a = in_a; m_b = in_b; m_idx = 0; m_busy = 1'b1;
                end
                if (acc) begin
                    acc_a.push_back(in_a);
                    acc_b.push_back(in_b);
                end
            end
        end
    end

    // Per-cycle compare against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                check("bit_valid", bit_valid, m_busy);
                check("busy", busy, m_busy);
                check("in_ready", in_ready, exp_ready());
                check("bit_a", bit_a, m_busy ? m_a[m_idx] : 1'b0);
                check("bit_b", bit_b, m_busy ? m_b[m_idx] : 1'b0);
                check("bit_first", bit_first, m_busy && m_idx == 0);
                check("bit_last", bit_last, m_busy && m_idx == W - 1);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        la.delete(); lb.delete(); lf.delete(); ll.delete(); lcyc.delete();
    endtask

    // Present a pair and hold in_valid until it is accepted (bounded).
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        bit done = 1'b0;
        in_a = a; in_b = b; in_valid = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        if (!done) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic check_log(input string name, input int n, input logic [7:0] ea,
                             input logic [7:0] eb, input logic [7:0] ef, input logic [7:0] el,
                             input bit contiguous);
        logic [7:0] ga, gb, gf, gl;
        ga = '0; gb = '0; gf = '0; gl = '0;
        check({name, "_beats"}, la.size(), n);
        for (int i = 0; i < n && i < la.size(); i++) begin
            ga[i] = la[i]; gb[i] = lb[i]; gf[i] = lf[i]; gl[i] = ll[i];
        end
        check({name, "_a"}, ga, ea);
        check({name, "_b"}, gb, eb);
        check({name, "_first"}, gf, ef);
        check({name, "_last"}, gl, el);
        if (contiguous && lcyc.size() == n) check({name, "_nobubble"}, lcyc[n-1] - lcyc[0], n - 1);
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; bit_ready = 1'b1; in_a = '0; in_b = '0;
        v1 = 1'b0; br1 = 1'b1; a1 = '0; b1 = '0;
        #2;
        check("rst_bit_valid", bit_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_first_last", {bit_first, bit_last}, 0);
        check("rst_bits", {bit_a, bit_b}, 0);
        #10 reset = 1'b1;
        step(1);
        check("rel_in_ready", in_ready, 1);

        // Basic word.
        clear_log();
        send(4'b1010, 4'b1010);
        step(5);
        check_log("basic", 4, 8'b0000_1010, 8'b0000_1010, 8'b0000_0001, 8'b0000_1000, 1'b1);
        check("basic_idle_ready", in_ready, 1);
        check("basic_idle_valid", bit_valid, 0);

        // WIDTH=1 single beat.
        a1 = 1'b1; b1 = 1'b0; v1 = 1'b1;
        @(posedge clk); #1;
        v1 = 1'b0;
        check("w1_beat", {bv1, ba1, bb1, bf1, bl1}, 5'b11011);
        step(1);
        check("w1_done", bv1, 0);

        // Back-to-back words.
        clear_log();
        send(4'b1010, 4'b1010);
        send(4'b1100, 4'b1101);
        step(6);
        check_log("b2b", 8, 8'b1100_1010, 8'b1101_1010, 8'b0001_0001, 8'b1000_1000, 1'b1);

        // Backpressure on beat 2.
        clear_log();
        send(4'b1100, 4'b1101);
        step(1);
        bit_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_hold", {bit_valid, bit_a, bit_b, bit_first, bit_last}, 5'b10000);
        end
        @(posedge clk); #1;
        bit_ready = 1'b1;
        step(6);
        check_log("stall", 4, 8'b0000_1100, 8'b0000_1101, 8'b0000_0001, 8'b0000_1000, 1'b0);

        // in_valid while busy is ignored until the last beat.
        clear_log();
        send(4'b0001, 4'b0000);
        in_a = 4'b1111; in_b = 4'b1111; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("busy_not_ready", in_ready, 0);
        end
        @(negedge clk);
        check("busy_last_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        step(6);
        check_log("ignore", 8, 8'b1111_0001, 8'b1111_0000, 8'b0001_0001, 8'b1000_1000, 1'b1);

        // Reset mid-word.
        send(4'b1010, 4'b0101);
        step(2);
        #2 reset = 1'b0;
        #1;
        check("midrst_outs", {bit_valid, busy, bit_first, bit_last, bit_a, bit_b}, 6'b0);
        clear_log();
        step(2);
        #2 reset = 1'b1;
        step(1);
        check("midrst_ready", in_ready, 1);
        check("midrst_valid", bit_valid, 0);
        step(4);
        check("midrst_stale", la.size(), 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bit_ready = ($urandom_range(0, 3) != 0);
            in_valid  = $urandom_range(0, 1);
            in_a      = W'($urandom);
            in_b      = W'($urandom);
            step(1);
        end
        in_valid  = 1'b0;
        bit_ready = 1'b1;
        step(12);
        check("drain", acc_a.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
